fitness_eval: RTL and testbench

- Downstream consumer of the initial-population generator.
- On start, snapshots the flat population vector and a target genome, then splits the population into fixed-width individuals.
- Scores each individual as the count of bit positions matching the target, and streams the per-individual scores.
- Reports the best individual, with a start/done handshake matching the population generator's.

---
 rtl/fitness_eval.sv | 145 ++++++++++++++
 tb/tb_fitness_eval.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fitness_eval.sv
// Population fitness evaluator: snapshots a flat population and a target genome,
// scores each individual by matching-bit count, streams the scores and tracks the best.
module fitness_eval #(
    parameter int POP_BITS  = 7500,
    parameter int IND_BITS  = 150,
    parameter int WORD_BITS = 30,
    localparam int NUM_IND  = POP_BITS / IND_BITS,
    localparam int WORDS    = IND_BITS / WORD_BITS,
    localparam int IDX_W    = $clog2(NUM_IND),
    localparam int SC_W     = $clog2(IND_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [POP_BITS-1:0] population,
    input  logic [IND_BITS-1:0] target,
    output logic                score_valid,
    output logic [IDX_W-1:0]    score_idx,
    output logic [SC_W-1:0]     score_val,
    output logic [IDX_W-1:0]    best_idx,
    output logic [SC_W-1:0]     best_score,
    output logic                busy,
    output logic                done
);

    localparam int WD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          state_r;
    logic [POP_BITS-1:0] pop_snap_r;
    logic [IND_BITS-1:0] tgt_snap_r;
    logic [IDX_W-1:0]    ind_r;
    logic [WD_W-1:0]     word_r;
    logic [SC_W-1:0]     acc_r;

    logic [SC_W-1:0]     match_cnt_s;
    logic [SC_W-1:0]     acc_next_s;
    logic                last_word_s;
    logic                last_ind_s;

    function automatic logic [SC_W-1:0] popcount(input logic [WORD_BITS-1:0] v);
        logic [SC_W-1:0] c;
        c = '0;
        for (int k = 0; k < WORD_BITS; k++) begin
            c = c + SC_W'(v[k]);
        end
        return c;
    endfunction

    // Score the word currently at the bottom of the shifting snapshots.
    always_comb begin
        match_cnt_s = popcount(~(pop_snap_r[WORD_BITS-1:0] ^ tgt_snap_r[WORD_BITS-1:0]));
        acc_next_s  = acc_r + match_cnt_s;
        last_word_s = (word_r == WD_W'(WORDS - 1));
        last_ind_s  = (ind_r == IDX_W'(NUM_IND - 1));
    end

    // Sequencer, snapshot shifting, accumulation and result registers.
    // The population snapshot shifts down one word per SCAN cycle while the target
    // rotates, so both compare slices always sit at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pop_snap_r  <= '0;
            tgt_snap_r  <= '0;
            ind_r       <= '0;
            word_r      <= '0;
            acc_r       <= '0;
            score_valid <= 1'b0;
            score_idx   <= '0;
            score_val   <= '0;
            best_idx    <= '0;
            best_score  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            done        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    pop_snap_r <= population;
                    tgt_snap_r <= target;
                    ind_r      <= '0;
                    word_r     <= '0;
                    acc_r      <= '0;
                    best_idx   <= '0;
                    best_score <= '0;
                    busy       <= 1'b1;
                    state_r    <= ST_SCAN;
                end
                ST_SCAN: begin
                    pop_snap_r <= {{WORD_BITS{1'b0}}, pop_snap_r[POP_BITS-1:WORD_BITS]};
                    tgt_snap_r <= {tgt_snap_r[WORD_BITS-1:0], tgt_snap_r[IND_BITS-1:WORD_BITS]};
                    if (last_word_s) begin
                        score_valid <= 1'b1;
                        score_idx   <= ind_r;
                        score_val   <= acc_next_s;
                        // Strict compare so ties keep the lower index.
                        if ((acc_next_s > best_score) || (ind_r == '0)) begin
                            best_score <= acc_next_s;
                            best_idx   <= ind_r;
                        end else begin
                            best_score <= best_score;
                        end
                        acc_r  <= '0;
                        word_r <= '0;
                        ind_r  <= ind_r + IDX_W'(1);
                        if (last_ind_s) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                        end
                    end else begin
                        acc_r  <= acc_next_s;
                        word_r <= word_r + WD_W'(1);
                        busy   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fitness_eval.sv
// Directed bench for fitness_eval: per-cycle score stream, done timing, best tracking,
// snapshot isolation and asynchronous reset mid-scan.
module tb_fitness_eval;

    localparam int POP = 7500;
    localparam int IND = 150;
    localparam int NI  = 50;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [POP-1:0] population;
    logic [IND-1:0] target;
    logic           score_valid;
    logic [5:0]     score_idx;
    logic [7:0]     score_val;
    logic [5:0]     best_idx;
    logic [7:0]     best_score;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;

    fitness_eval dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .population  (population),
        .target      (target),
        .score_valid (score_valid),
        .score_idx   (score_idx),
        .score_val   (score_val),
        .best_idx    (best_idx),
        .best_score  (best_score),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_score(input logic [POP-1:0] p, input logic [IND-1:0] t, input int i);
        int s = 0;
        for (int j = 0; j < IND; j++) begin
            if (p[i*IND + j] == t[j]) s++;
        end
        return s;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_score_valid"}, 32'(score_valid), 32'd0);
        check({tag, "_score_idx"},   32'(score_idx),   32'd0);
        check({tag, "_score_val"},   32'(score_val),   32'd0);
        check({tag, "_best_idx"},    32'(best_idx),    32'd0);
        check({tag, "_best_score"},  32'(best_score),  32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
    endtask

    // One full evaluation; cycle 0 is the cycle in which start is sampled.
    task automatic run(input string name, input logic [POP-1:0] p, input logic [IND-1:0] t,
                       input int hand_idx, input int hand_score, input bit mutate);
        int sc[NI];
        int mb  = 0;
        int mbs = 0;
        int n   = 0;
        bit exp_sv;
        for (int i = 0; i < NI; i++) begin
            sc[i] = model_score(p, t, i);
            if (i == 0 || sc[i] > mbs) begin
                mb  = i;
                mbs = sc[i];
            end
        end
        @(negedge clk);
        population = p;
        target     = t;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 258; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (mutate && cyc == 3) begin
                population = '0;
                target     = '0;
            end
            if (mutate && cyc == 100) start = 1'b1;
            if (mutate && cyc == 101) start = 1'b0;
            exp_sv = (cyc >= 7) && (cyc <= 252) && ((cyc - 2) % 5 == 0);
            check({name, "_score_valid"}, 32'(score_valid), 32'(exp_sv));
            check({name, "_done"}, 32'(done), 32'(cyc == 252));
            if (score_valid && n < NI) begin
                check({name, "_score_idx"}, 32'(score_idx), 32'(n));
                check({name, "_score_val"}, 32'(score_val), 32'(sc[n]));
                n++;
            end
            if (cyc == 1 || cyc == 251) check({name, "_busy_hi"}, 32'(busy), 32'd1);
            if (cyc == 252 || cyc == 258) begin
                check({name, "_busy_lo"}, 32'(busy), 32'd0);
                check({name, "_best_idx_model"}, 32'(best_idx), 32'(mb));
                check({name, "_best_score_model"}, 32'(best_score), 32'(mbs));
                check({name, "_best_idx_hand"}, 32'(best_idx), 32'(hand_idx));
                check({name, "_best_score_hand"}, 32'(best_score), 32'(hand_score));
            end
        end
        check({name, "_pulse_count"}, 32'(n), 32'(NI));
    endtask

    logic [IND-1:0] ones_t;
    logic [IND-1:0] a5_t;
    logic [POP-1:0] zero_p;
    logic [POP-1:0] match_p;
    logic [POP-1:0] winner_p;
    logic [POP-1:0] tie_p;
    logic [7:0]     a5_byte;
    int             k;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        population = '0;
        target     = '0;

        ones_t  = '1;
        zero_p  = '0;
        a5_byte = 8'hA5;
        for (int j = 0; j < IND; j++) a5_t[j] = a5_byte[j % 8];
        for (int i = 0; i < NI; i++) begin
            match_p[i*IND +: IND] = a5_t;
            if (i == 37) begin
                winner_p[i*IND +: IND] = '1;
            end else begin
                winner_p[i*IND +: IND] = '0;
                for (int j = 0; j < 10; j++) winner_p[i*IND + j*15] = 1'b1;
            end
            k = (i == 5 || i == 12) ? 30 : 31 + (i % 40);
            tie_p[i*IND +: IND] = a5_t;
            for (int j = 0; j < k; j++) tie_p[i*IND + j] = ~a5_t[j];
        end

        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("after_reset");

        run("zeros_vs_ones", zero_p,   ones_t, 0,  0,   1'b0);
        run("perfect",       match_p,  a5_t,   0,  150, 1'b0);
        run("winner",        winner_p, ones_t, 37, 150, 1'b0);
        run("tie",           tie_p,    a5_t,   5,  120, 1'b0);
        run("snapshot",      match_p,  a5_t,   0,  150, 1'b1);

        // Asynchronous reset, off the clock edges, in cycle 60 of a run.
        @(negedge clk);
        population = winner_p;
        target     = ones_t;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_scan_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle_busy", 32'(busy), 32'd0);
        check("post_reset_idle_sv", 32'(score_valid), 32'd0);
        run("after_reset", tie_p, a5_t, 5, 120, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
